// File: rtl/trap_controller.sv
// trap_controller: trap/interrupt arbitration for a small CPU.
//
// Sorts level interrupt lines and a page-fault pulse into one offered trap.
// It also keeps the kernel register bank select, the global interrupt enable
// and a double-fault halt flag.
//
// Trap numbers: 0 = none, 1 = fault, 2+i = channel i, all ones = double fault.
//
// Handshake: the block offers a trap by holding irq (or fault) high.
// The CPU accepts the trap by raising take for one cycle.
// The offer stays up and unchanged until take, fault_in or reset.
// It is not withdrawn by mask or ie writes.
// reti is a one-cycle strobe that is honoured only in SERVICE.
//
// Optional feature: define TRAP_CTRL_RR_EN for round-robin channel selection.
// With it, the search starts at the channel after the last taken one.
// Without it, selection is fixed priority and the lowest index wins.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   irq_in[NIRQ]          level interrupt lines (rising edge sets pending)
//   fault_in              page-fault pulse, not maskable
//   take                  CPU accepts the offered trap
//   reti                  return-from-interrupt strobe
//   mask_we/mask_wdata    mask register write (1 = channel masked)
//   ie_we/ie_wdata        global enable write (honoured in IDLE only)
//   irq, fault            interrupt / fault offered
//   trapnr                trap number of offered or serviced trap
//   bank, ie, hlt         kernel bank select, global enable, double-fault halt
//   pending               raw pending latches
//   state_dbg             current FSM state encoding (debug visibility)
module trap_controller #(
  parameter int NIRQ  = 8,
  parameter int TRAPW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic             fault_in,
  input  logic             take,
  input  logic             reti,
  input  logic             mask_we,
  input  logic [NIRQ-1:0]  mask_wdata,
  input  logic             ie_we,
  input  logic             ie_wdata,
  output logic             irq,
  output logic             fault,
  output logic [TRAPW-1:0] trapnr,
  output logic             bank,
  output logic             ie,
  output logic             hlt,
  output logic [NIRQ-1:0]  pending,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FAULT   = 3'd2,
    SERVICE = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [NIRQ-1:0]   irq_prev;
  logic [NIRQ-1:0]   mask, mask_nx;
  logic [NIRQ-1:0]   pending_nx, clr, rise, avail;
  logic [4:0]        sel, sel_nx;     // channel latched on entry to REQ
  logic [4:0]        pick;
  logic              hit;
  logic              irq_nx, fault_nx, bank_nx, ie_nx, hlt_nx;
  logic [TRAPW-1:0]  trapnr_nx;
`ifdef TRAP_CTRL_RR_EN
  logic [4:0]        last, last_nx; // last channel taken, search starts after it
`endif

  assign rise      = irq_in & ~irq_prev;
  assign avail     = pending & ~mask;
  assign state_dbg = state;

  // Channel selection over the unmasked pending set.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
`ifdef TRAP_CTRL_RR_EN
    // The loop walks offsets from far to near, so the nearest hit is the one
    // that stays assigned.
    for (int k = NIRQ; k >= 1; k--) begin
      for (int i = 0; i < NIRQ; i++) begin
        if (avail[i] &&
            ((int'(last) + k == i) || (int'(last) + k - NIRQ == i))) begin
          hit  = 1'b1;
          pick = 5'(i);
        end
      end
    end
`else
    // The loop walks from high index to low, so the lowest index wins.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        hit  = 1'b1;
        pick = 5'(i);
      end
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx  = state;
    irq_nx    = irq;
    fault_nx  = fault;
    bank_nx   = bank;
    ie_nx     = ie;
    hlt_nx    = hlt;
    trapnr_nx = trapnr;
    sel_nx    = sel;
    clr       = '0;
    mask_nx   = mask_we ? mask_wdata : mask;
`ifdef TRAP_CTRL_RR_EN
    last_nx   = last;
`endif

    case (state)
      IDLE: begin
        irq_nx    = 1'b0;
        fault_nx  = 1'b0;
        bank_nx   = 1'b0;
        trapnr_nx = '0;
        if (ie_we) ie_nx = ie_wdata;
        if (fault_in) begin
          state_nx  = FAULT;
          fault_nx  = 1'b1;
          trapnr_nx = TRAPW'(1);
          bank_nx   = 1'b1;
        end else if (ie && hit) begin
          state_nx  = REQ;
          irq_nx    = 1'b1;
          sel_nx    = pick;
          trapnr_nx = TRAPW'(pick) + TRAPW'(2);
        end
      end
      REQ: begin
        // A fault preempts the offer, and the pending bit is kept for later.
        if (fault_in) begin
          state_nx  = FAULT;
          irq_nx    = 1'b0;
          fault_nx  = 1'b1;
          trapnr_nx = TRAPW'(1);
          bank_nx   = 1'b1;
        end else if (take) begin
          state_nx = SERVICE;
          irq_nx   = 1'b0;
          bank_nx  = 1'b1;
          ie_nx    = 1'b0;
          for (int i = 0; i < NIRQ; i++)
            if (sel == 5'(i)) clr[i] = 1'b1;
`ifdef TRAP_CTRL_RR_EN
          last_nx = sel;
`endif
        end
      end
      FAULT: begin
        if (take) begin
          state_nx = SERVICE;
          fault_nx = 1'b0;
          ie_nx    = 1'b0;
        end
      end
      SERVICE: begin
        if (fault_in) begin
          state_nx  = HALT;
          hlt_nx    = 1'b1;
          trapnr_nx = '1;
          bank_nx   = 1'b1;
        end else if (reti) begin
          state_nx  = IDLE;
          bank_nx   = 1'b0;
          ie_nx     = 1'b1;
          trapnr_nx = '0;
        end
      end
      HALT: begin
        // Only reset leaves HALT.
      end
      default: state_nx = IDLE;
    endcase

    // A new edge on the same channel wins over the take-time clear.
    pending_nx = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '1;
      ie       <= 1'b0;
      bank     <= 1'b0;
      irq      <= 1'b0;
      fault    <= 1'b0;
      hlt      <= 1'b0;
      trapnr   <= '0;
      sel      <= '0;
`ifdef TRAP_CTRL_RR_EN
      last     <= 5'(NIRQ - 1);
`endif
    end else begin
      state    <= state_nx;
      irq_prev <= irq_in;
      pending  <= pending_nx;
      mask     <= mask_nx;
      ie       <= ie_nx;
      bank     <= bank_nx;
      irq      <= irq_nx;
      fault    <= fault_nx;
      hlt      <= hlt_nx;
      trapnr   <= trapnr_nx;
      sel      <= sel_nx;
`ifdef TRAP_CTRL_RR_EN
      last     <= last_nx;
`endif
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller (NIRQ=8, TRAPW=4).
// Inputs are driven #1 after a rising edge, and outputs are sampled #1 after
// the following rising edge.
module tb_trap_controller;
  localparam int NIRQ  = 8;
  localparam int TRAPW = 4;

`ifdef TRAP_CTRL_RR_EN
  localparam logic [3:0] FIRST_NR  = 4'd6;
  localparam logic [3:0] SECOND_NR = 4'd3;
  localparam logic [7:0] AFTER_1ST = 8'h02;
`else
  localparam logic [3:0] FIRST_NR  = 4'd3;
  localparam logic [3:0] SECOND_NR = 4'd6;
  localparam logic [7:0] AFTER_1ST = 8'h10;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_FAULT = 3'd2,
                         S_SERVICE = 3'd3, S_HALT = 3'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NIRQ-1:0]  irq_in = '0;
  logic             fault_in = 1'b0, take = 1'b0, reti = 1'b0;
  logic             mask_we = 1'b0, ie_we = 1'b0, ie_wdata = 1'b0;
  logic [NIRQ-1:0]  mask_wdata = '0;
  logic             irq, fault, bank, ie, hlt;
  logic [TRAPW-1:0] trapnr;
  logic [NIRQ-1:0]  pending;
  logic [2:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  trap_controller #(.NIRQ(NIRQ), .TRAPW(TRAPW)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .fault_in(fault_in),
    .take(take), .reti(reti), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ie_we(ie_we), .ie_wdata(ie_wdata), .irq(irq), .fault(fault),
    .trapnr(trapnr), .bank(bank), .ie(ie), .hlt(hlt), .pending(pending),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   32'(state_dbg), 32'(S_IDLE));
    check({tag, "_irq"},     32'(irq),       32'd0);
    check({tag, "_fault"},   32'(fault),     32'd0);
    check({tag, "_hlt"},     32'(hlt),       32'd0);
    check({tag, "_bank"},    32'(bank),      32'd0);
    check({tag, "_ie"},      32'(ie),        32'd0);
    check({tag, "_trapnr"},  32'(trapnr),    32'd0);
    check({tag, "_pending"}, 32'(pending),   32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Unmask everything and enable interrupts.
    mask_we = 1'b1; mask_wdata = 8'h00; ie_we = 1'b1; ie_wdata = 1'b1;
    tick();
    mask_we = 1'b0; ie_we = 1'b0;
    check("ie_set", 32'(ie), 32'd1);

    // Channel 3 rises: pending is set next cycle, and irq follows one cycle later.
    irq_in = 8'h08;
    tick();
    check("p3_set", 32'(pending), 32'h08);
    check("p3_irq_early", 32'(irq), 32'd0);
    tick();
    check("p3_irq", 32'(irq), 32'd1);
    check("p3_trapnr", 32'(trapnr), 32'd5);
    take = 1'b1;
    tick();
    take = 1'b0;
    check("p3_bank", 32'(bank), 32'd1);
    check("p3_ie", 32'(ie), 32'd0);
    check("p3_pend_clr", 32'(pending), 32'h00);
    check("p3_state", 32'(state_dbg), 32'(S_SERVICE));

    // In SERVICE, channel 0 rises and is held pending without an offer.
    irq_in = 8'h09;
    tick();
    check("p0_pend", 32'(pending), 32'h01);
    tick();
    check("p0_no_irq", 32'(irq), 32'd0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("reti_bank", 32'(bank), 32'd0);
    check("reti_ie", 32'(ie), 32'd1);
    tick();
    check("p0_irq", 32'(irq), 32'd1);
    check("p0_trapnr", 32'(trapnr), 32'd2);
    take = 1'b1; tick(); take = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;

    // Offer channel 3 again, then apply fault and take in the same cycle.
    irq_in = 8'h00;
    tick();
    irq_in = 8'h08;
    tick();
    tick();
    check("req5_trapnr", 32'(trapnr), 32'd5);
    fault_in = 1'b1; take = 1'b1;
    tick();
    fault_in = 1'b0; take = 1'b0;
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_irq", 32'(irq), 32'd0);
    check("flt_trapnr", 32'(trapnr), 32'd1);
    check("flt_pend_kept", 32'(pending), 32'h08);
    check("flt_bank", 32'(bank), 32'd1);

    // take in FAULT, then a second fault in SERVICE halts the block.
    take = 1'b1; tick(); take = 1'b0;
    check("flt_svc_state", 32'(state_dbg), 32'(S_SERVICE));
    check("flt_svc_ie", 32'(ie), 32'd0);
    fault_in = 1'b1; tick(); fault_in = 1'b0;
    check("dbl_hlt", 32'(hlt), 32'd1);
    check("dbl_trapnr", 32'(trapnr), 32'hF);
    take = 1'b1; reti = 1'b1;
    tick();
    take = 1'b0; reti = 1'b0;
    check("halt_stuck", 32'(state_dbg), 32'(S_HALT));
    check("halt_hlt", 32'(hlt), 32'd1);
    check("halt_bank", 32'(bank), 32'd1);
    // Reset takes priority even with other strobes active in the same cycle.
    reset = 1'b1; irq_in = 8'h00; reti = 1'b1; fault_in = 1'b1;
    tick();
    reset = 1'b0; reti = 1'b0; fault_in = 1'b0;
    check_reset_values("halt_rst");

    // Channel selection order: take channel 1 first, then raise 1 and 4 together.
    mask_we = 1'b1; mask_wdata = 8'h00; ie_we = 1'b1; ie_wdata = 1'b1;
    tick();
    mask_we = 1'b0; ie_we = 1'b0;
    irq_in = 8'h02; tick(); tick();
    check("c1_trapnr", 32'(trapnr), 32'd3);
    take = 1'b1; tick(); take = 1'b0;
    irq_in = 8'h00; tick();
    irq_in = 8'h12; tick();
    check("c14_pend", 32'(pending), 32'h12);
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    check("order_first", 32'(trapnr), 32'(FIRST_NR));
    take = 1'b1; tick(); take = 1'b0;
    check("order_pend", 32'(pending), 32'(AFTER_1ST));
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    check("order_second", 32'(trapnr), 32'(SECOND_NR));
    take = 1'b1; tick(); take = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;

    // A fully masked pending bit gives no offer until the mask opens.
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    irq_in = 8'h16; tick();
    check("m_pend", 32'(pending), 32'h04);
    tick();
    check("m_no_irq", 32'(irq), 32'd0);
    mask_we = 1'b1; mask_wdata = 8'hFB; tick(); mask_we = 1'b0;
    check("m_irq_lag", 32'(irq), 32'd0);
    tick();
    check("m_irq", 32'(irq), 32'd1);
    check("m_trapnr", 32'(trapnr), 32'd4);

    // A mask write in REQ does not withdraw the offer.
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    check("req_hold_irq", 32'(irq), 32'd1);
    check("req_hold_nr", 32'(trapnr), 32'd4);
    take = 1'b1; tick(); take = 1'b0;
    // ie_we is ignored outside IDLE, and reti wins over a simultaneous ie_we.
    ie_we = 1'b1; ie_wdata = 1'b1; tick(); ie_we = 1'b0;
    check("svc_iewe_ign", 32'(ie), 32'd0);
    reti = 1'b1; ie_we = 1'b1; ie_wdata = 1'b0;
    tick();
    reti = 1'b0; ie_we = 1'b0;
    check("reti_wins_ie", 32'(ie), 32'd1);
    check("reti_idle", 32'(state_dbg), 32'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameters SHALL be: NIRQ, 8, number of interrupt channels (1..13); TRAPW, 4, trap number width.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset; clock is clk.
REQ-004 Port irq_in  input  NIRQ  level interrupt lines; bit i = channel i.
REQ-005 Port fault_in  input  1  page-fault pulse; not maskable.
REQ-006 Port take  input  1  CPU accepts the offered trap; sampled at the FETCH boundary.
REQ-007 Port reti  input  1  CPU return-from-interrupt strobe.
REQ-008 Port mask_we, mask_wdata  input  1, NIRQ  write strobe and data for the mask register (1 = channel masked).
REQ-009 Port ie_we, ie_wdata  input  1, 1  software write of the global interrupt enable.
REQ-010 Port irq, fault  output  1, 1  interrupt offered, fault offered.
REQ-011 Port trapnr  output  TRAPW  trap number of the offered or serviced trap.
REQ-012 Port bank, ie, hlt  output  1, 1, 1  kernel register bank select, global enable, double-fault halt.
REQ-013 Port pending  output  NIRQ  raw pending latches.

Function
REQ-014 Trap numbers SHALL be 0 = none, 1 = fault, 2+i = channel i, all ones = double fault.
REQ-015 The block SHALL register irq_in; pending[i] SHALL set on the edge where irq_in[i]=1 and the registered previous value=0.
REQ-016 When a set and a clear of the same pending bit coincide, the set SHALL win.
REQ-017 The FSM SHALL have states IDLE, REQ, FAULT, SERVICE, HALT.
REQ-018 IDLE->REQ SHALL occur when ie=1 and (pending & ~mask)!=0; trapnr SHALL latch the selected channel on entry.
REQ-019 In REQ: irq=1; mask or ie writes SHALL NOT withdraw the offer; take SHALL clear the selected pending bit, set bank=1 and ie=0, and go to SERVICE.
REQ-020 fault_in in IDLE or REQ SHALL go to FAULT: irq=0, fault=1, trapnr=1, bank=1; pending bits SHALL be unchanged.
REQ-021 fault_in together with take in REQ: fault SHALL win and the pending bit SHALL be kept.
REQ-022 take in FAULT SHALL go to SERVICE with ie=0.
REQ-023 reti in SERVICE SHALL go to IDLE with bank=0 and ie=1; reti in any other state SHALL be ignored.
REQ-024 fault_in in SERVICE SHALL go to HALT: hlt=1, trapnr=all ones, bank=1; only reset SHALL exit HALT.
REQ-025 ie_we SHALL load ie in IDLE only; reti SHALL win over a simultaneous ie_we.
REQ-026 mask_we SHALL load mask in any state; the new mask SHALL apply from the next cycle.
REQ-027 All outputs SHALL be registered; irq SHALL assert one cycle after the qualifying pending bit is set.

Reset
REQ-028 On reset: state=IDLE, pending=0, previous irq_in=0, mask=all ones, ie=0, bank=0, irq=0, fault=0, hlt=0, trapnr=0.
REQ-029 Reset asserted mid-operation, including in HALT, SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro TRAP_CTRL_RR_EN defined: channel selection SHALL be round-robin, starting from the channel after the last taken one.
REQ-031 Macro TRAP_CTRL_RR_EN undefined: channel selection SHALL be fixed priority, lowest index first.

Verification
REQ-032 Reset; mask=0, ie=1; irq_in[3] rises -> pending[3]=1 next cycle, then irq=1 with trapnr=5; take -> bank=1, ie=0, pending[3]=0.
REQ-033 In SERVICE, irq_in[0] rises -> pending[0]=1 and irq stays 0; reti -> bank=0, ie=1, then irq=1 with trapnr=2.
REQ-034 In REQ with trapnr=5, fault_in and take in the same cycle -> fault=1, trapnr=1, pending[3] stays 1.
REQ-035 In SERVICE, fault_in -> hlt=1, trapnr=15; take and reti have no effect; reset -> all reset values.
REQ-036 Channels 1 and 4 pending, mask=0: without TRAP_CTRL_RR_EN, order is 3 then 6; with it, channel 1 taken previously -> 6 is offered first.
REQ-037 mask=0xFF, ie=1, irq_in[2] rises -> no irq; mask_we with 0xFB -> irq=1 with trapnr=4 two cycles later.
